// File: rtl/checker_pkg.sv
// Shared state and result encodings for the data-memory write checker.
package checker_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_t;

  typedef enum logic [1:0] {FC_NONE, FC_MISMATCH, FC_TIMEOUT, FC_CONFIG} fail_code_t;

endpackage

// File: rtl/chk_exp_table.sv
// Expected-write table: one synchronous write port, one combinational read port.
// Read data follows rd_idx in the same cycle; no backpressure.
module chk_exp_table #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_EXP  = 4,
  localparam int IDX_W = (N_EXP > 1) ? $clog2(N_EXP) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] addr_mem [N_EXP];
  logic [DATA_W-1:0] data_mem [N_EXP];

  // Contents are intentionally left unreset; software reloads before every start.
  always_ff @(posedge clk) begin
    if (we && (int'(wr_idx) < N_EXP)) begin
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_addr = addr_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the data-memory write port against an ordered expected-write table and reports pass/fail.
// Verdict registered on the edge that samples the deciding write; passive observer, no backpressure.
module mem_write_checker
  import checker_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                N_EXP    = 4,
  parameter logic [ADDR_W-1:0] IGN_BASE = 32'd80,
  parameter logic [ADDR_W-1:0] IGN_MASK = 32'hFFFF_FFFC,
  parameter int                TIMEOUT  = 4096,
  localparam int IDX_W = (N_EXP > 1) ? $clog2(N_EXP) : 1,
  localparam int CNT_W = $clog2(N_EXP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [CNT_W-1:0]  exp_count,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [15:0]       ign_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam int               TO_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] NEXP_C  = CNT_W'(N_EXP);

  chk_state_t        state;
  fail_code_t        fc;
  logic [CNT_W-1:0]  cnt_lat;
  logic [TO_W-1:0]   cyc;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  match_nxt;
  logic              hit, in_win, mismatch, cfg_bad;

  chk_exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_EXP  (N_EXP)
  ) u_table (
    .clk     (clk),
    .we      (exp_we && (state == IDLE)),
    .wr_idx  (exp_idx),
    .wr_addr (exp_addr),
    .wr_data (exp_data),
    .rd_idx  (match_cnt[IDX_W-1:0]),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign match_nxt = match_cnt + 1'b1;
  assign hit       = memwrite && (dataadr == rd_addr) && (writedata == rd_data);
  assign in_win    = (dataadr & IGN_MASK) == (IGN_BASE & IGN_MASK);
  // An expected write inside the scratch window is still a match.
  assign mismatch  = memwrite && !hit && !in_win;
  assign cfg_bad   = (exp_count == '0) || (exp_count > NEXP_C);
  assign fail_code = fc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fc        <= FC_NONE;
      done      <= 1'b0;
      pass      <= 1'b0;
      match_cnt <= '0;
      ign_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      cnt_lat   <= '0;
      cyc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt_lat   <= exp_count;
            match_cnt <= '0;
            ign_cnt   <= '0;
            cyc       <= '0;
            if (cfg_bad) begin
              state <= FAIL;
              done  <= 1'b1;
              fc    <= FC_CONFIG;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          cyc <= cyc + 1'b1;
          if (hit) begin
            match_cnt <= match_nxt;
          end else if (memwrite && in_win && (ign_cnt != 16'hFFFF)) begin
            ign_cnt <= ign_cnt + 1'b1;
          end
          // Terminal match beats a coincident timeout.
          if (hit && (match_nxt == cnt_lat)) begin
            state <= PASS;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (mismatch) begin
            state     <= FAIL;
            done      <= 1'b1;
            fc        <= FC_MISMATCH;
            fail_addr <= dataadr;
            fail_data <= writedata;
          end else if (cyc == TO_LAST) begin
            state <= FAIL;
            done  <= 1'b1;
            fc    <= FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker with a short timeout so every scenario fits in a few cycles.
module tb_mem_write_checker;

  logic        clk;
  logic        reset;
  logic        exp_we;
  logic [1:0]  exp_idx;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  logic [2:0]  exp_count;
  logic        start;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [2:0]  match_cnt;
  logic [15:0] ign_cnt;
  logic [31:0] fail_addr;
  logic [31:0] fail_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        p;
    logic [1:0]  code;
    logic [2:0]  mcnt;
    logic [15:0] icnt;
    logic [31:0] faddr;
    logic [31:0] fdata;
  } exp_t;

  exp_t sbq[$];

  mem_write_checker #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .N_EXP    (4),
    .IGN_BASE (32'd80),
    .IGN_MASK (32'hFFFF_FFFC),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .exp_we    (exp_we),
    .exp_idx   (exp_idx),
    .exp_addr  (exp_addr),
    .exp_data  (exp_data),
    .exp_count (exp_count),
    .start     (start),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code),
    .match_cnt (match_cnt),
    .ign_cnt   (ign_cnt),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic [1:0] code, input logic [2:0] mcnt,
                          input logic [15:0] icnt, input logic [31:0] faddr, input logic [31:0] fdata);
    exp_t e;
    e.p = p; e.code = code; e.mcnt = mcnt; e.icnt = icnt; e.faddr = faddr; e.fdata = fdata;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = idx; exp_addr = a; exp_data = d;
    @(negedge clk) exp_we = 1'b0;
  endtask

  task automatic start_run(input logic [2:0] cnt);
    start = 1'b1; exp_count = cnt;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    @(negedge clk) memwrite = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_sbq"}, 64'(sbq.size()), 64'(1));
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_pass"}, 64'(pass), 64'(e.p));
      chk({tag, "_code"}, 64'(fail_code), 64'(e.code));
      chk({tag, "_match"}, 64'(match_cnt), 64'(e.mcnt));
      chk({tag, "_ign"}, 64'(ign_cnt), 64'(e.icnt));
      chk({tag, "_faddr"}, 64'(fail_addr), 64'(e.faddr));
      chk({tag, "_fdata"}, 64'(fail_data), 64'(e.fdata));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_pass"}, 64'(pass), 64'(0));
    chk({tag, "_code"}, 64'(fail_code), 64'(0));
    chk({tag, "_match"}, 64'(match_cnt), 64'(0));
    chk({tag, "_ign"}, 64'(ign_cnt), 64'(0));
    chk({tag, "_faddr"}, 64'(fail_addr), 64'(0));
    chk({tag, "_fdata"}, 64'(fail_data), 64'(0));
  endtask

  initial begin
    reset = 1'b0; exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
    exp_count = '0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1'b1;

    // Legacy program: scratch write then the real result
    @(negedge clk);
    load(2'd0, 32'd84, 32'd7);
    push_exp(1'b1, 2'd0, 3'd1, 16'd1, 32'd0, 32'd0);
    start_run(3'd1);
    wr(32'd80, 32'd123);
    wr(32'd84, 32'd7);
    wait_done("legacy");
    // PASS must ignore further writes and starts
    wr(32'd99, 32'd99);
    start_run(3'd0);
    chk("sticky_pass", 64'(pass), 64'(1));
    chk("sticky_code", 64'(fail_code), 64'(0));

    do_reset();
    load(2'd0, 32'd84, 32'd7);
    load(2'd1, 32'd88, 32'd9);
    push_exp(1'b0, 2'd1, 3'd0, 16'd0, 32'd88, 32'd9);
    start_run(3'd2);
    wr(32'd88, 32'd9);
    wait_done("order");

    do_reset();
    load(2'd0, 32'd84, 32'd7);
    push_exp(1'b0, 2'd1, 3'd0, 16'd0, 32'd84, 32'd6);
    start_run(3'd1);
    wr(32'd84, 32'd6);
    wait_done("baddata");

    // Timeout with two scratch writes (83 is inside the masked window)
    do_reset();
    push_exp(1'b0, 2'd2, 3'd0, 16'd2, 32'd0, 32'd0);
    start_run(3'd1);
    wr(32'd80, 32'd1);
    wr(32'd83, 32'd2);
    repeat (13) @(negedge clk);
    chk("to_early", 64'(done), 64'(0));
    @(negedge clk);
    wait_done("timeout");

    do_reset();
    push_exp(1'b0, 2'd3, 3'd0, 16'd0, 32'd0, 32'd0);
    start_run(3'd0);
    chk("cfg0_now", 64'(done), 64'(1));
    wait_done("cfg0");

    do_reset();
    push_exp(1'b0, 2'd3, 3'd0, 16'd0, 32'd0, 32'd0);
    start_run(3'd5);
    chk("cfg5_now", 64'(done), 64'(1));
    wait_done("cfg5");

    // Expected write inside the scratch window counts as a match
    do_reset();
    load(2'd0, 32'd80, 32'd1);
    push_exp(1'b1, 2'd0, 3'd1, 16'd0, 32'd0, 32'd0);
    start_run(3'd1);
    wr(32'd80, 32'd1);
    wait_done("winmatch");

    // Table write and start in the same cycle use the new entry
    do_reset();
    load(2'd0, 32'd84, 32'd7);
    push_exp(1'b1, 2'd0, 3'd1, 16'd0, 32'd0, 32'd0);
    exp_we = 1'b1; exp_idx = 2'd0; exp_addr = 32'd92; exp_data = 32'd5;
    start = 1'b1; exp_count = 3'd1;
    @(negedge clk);
    exp_we = 1'b0; start = 1'b0;
    wr(32'd92, 32'd5);
    wait_done("samecyc");

    // Asynchronous reset mid-RUN, then a clean rerun
    do_reset();
    load(2'd0, 32'd84, 32'd7);
    load(2'd1, 32'd88, 32'd9);
    start_run(3'd2);
    wr(32'd84, 32'd7);
    chk("mid_match", 64'(match_cnt), 64'(1));
    chk("mid_done", 64'(done), 64'(0));
    #2 reset = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk) reset = 1'b1;
    load(2'd0, 32'd84, 32'd7);
    load(2'd1, 32'd88, 32'd9);
    push_exp(1'b1, 2'd0, 3'd2, 16'd0, 32'd0, 32'd0);
    start_run(3'd2);
    wr(32'd84, 32'd7);
    wr(32'd88, 32'd9);
    wait_done("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable self-checking monitor for the single-cycle MIPS `computer` data-memory write port. It watches `memwrite`/`dataadr`/`writedata` and compares each write against an ordered table of up to `N_EXP` expected writes. It ignores writes that fall in a configurable scratch window and reports pass, fail or timeout with a cause code. It replaces the hard-coded "7 to address 84, tolerate address 80" check, so the same check can run on FPGA as well as in simulation.

## Interface
- `ADDR_W`, 32, width of `dataadr`
- `DATA_W`, 32, width of `writedata`
- `N_EXP`, 4, depth of the expected-write table (≥1)
- `IGN_BASE`, 32'd80, scratch-window base address
- `IGN_MASK`, 32'hFFFF_FFFC, address bits compared against `IGN_BASE`
- `TIMEOUT`, 4096, cycles in RUN before a timeout failure (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `exp_we`  in  1  write one table entry (IDLE only)
- `exp_idx`  in  $clog2(N_EXP)  entry index
- `exp_addr`  in  ADDR_W  expected address
- `exp_data`  in  DATA_W  expected data
- `exp_count`  in  $clog2(N_EXP+1)  number of valid entries, sampled on `start`
- `start`  in  1  one-cycle pulse: IDLE→RUN
- `memwrite`  in  1  DUT write strobe
- `dataadr`  in  ADDR_W  DUT write address
- `writedata`  in  DATA_W  DUT write data
- `done`  out  1  high in PASS or FAIL
- `pass`  out  1  high in PASS
- `fail_code`  out  2  0 none, 1 mismatch, 2 timeout, 3 bad config
- `match_cnt`  out  $clog2(N_EXP+1)  expected writes matched so far
- `ign_cnt`  out  16  scratch writes ignored (saturating)
- `fail_addr`  out  ADDR_W  address of the offending write
- `fail_data`  out  DATA_W  data of the offending write

## Operation
- FSM states: IDLE, RUN, PASS, FAIL.
- IDLE
  - `exp_we` writes the table.
  - `start` latches `exp_count`.
  - If the latched count is 0 or greater than `N_EXP` → FAIL, code 3.
  - Otherwise → RUN, with `match_cnt`, `ign_cnt` and the cycle counter cleared.
- RUN, one `memwrite` evaluated per cycle, in priority order:
  1. `dataadr==exp_addr[match_cnt] && writedata==exp_data[match_cnt]` → `match_cnt`+1. If the new value equals the latched count → PASS.
  2. `(dataadr & IGN_MASK)==(IGN_BASE & IGN_MASK)` → `ign_cnt`+1, saturating at 16'hFFFF.
  3. Otherwise → FAIL, code 1, with `fail_addr`/`fail_data` captured.
- A match takes priority over the scratch window, so an expected write inside the window counts as a match.
- RUN cycle counter: increments each cycle. On reaching `TIMEOUT-1` with no terminal event that cycle → FAIL, code 2. If a terminal match and the timeout land in the same cycle, PASS wins.
- PASS and FAIL are sticky. They ignore `memwrite`, `start` and `exp_we`, and leave only on `reset`.
- `exp_we` outside IDLE is ignored.
- `exp_we` and `start` in the same cycle: the table write completes, and RUN compares against the new entry.

## Timing
- Reset values: state IDLE; `done`=0, `pass`=0, `fail_code`=0, `match_cnt`=0, `ign_cnt`=0, `fail_addr`=0, `fail_data`=0. Table contents are not reset.
- Reset asserted mid-RUN returns to IDLE immediately and asynchronously.
- Inputs are sampled on the rising edge of `clk`. The DUT's single-cycle write is stable across that edge.
- All outputs are registered. `done`/`pass` rise on the edge that samples the deciding write, so they are visible one cycle after the write's address/data phase.
- RUN entered on edge k: the first write evaluated is the one present at edge k+1.
- Table lookup is combinational from `match_cnt`, so there is no added compare latency.

## Structure
- Package `checker_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_t`
  - `typedef enum logic [1:0] {FC_NONE, FC_MISMATCH, FC_TIMEOUT, FC_CONFIG} fail_code_t`
- Sub-module `chk_exp_table`: `N_EXP`×(ADDR_W+DATA_W) register file with one write port and one asynchronous read port.
- The FSM, counters and capture registers live in `mem_write_checker`.

## Test plan
- Legacy program, table {84:7}, count 1; DUT writes 80:x then 84:7 → `pass`=1, `ign_cnt`=1, `match_cnt`=1.
- Ordered table {84:7, 88:9}; DUT writes 88:9 first → FAIL, code 1, `fail_addr`=88, `fail_data`=9, `match_cnt`=0.
- Table {84:7}; DUT writes 84:6 → FAIL, code 1, `fail_data`=6.
- `TIMEOUT`=16 with no `memwrite` after `start` → `done` rises on the 16th RUN edge, code 2.
- `start` with `exp_count`=0 → FAIL, code 3 on the next edge. Also `exp_count`=N_EXP+1 → code 3.
- `reset` pulsed low mid-RUN after 1 match → all outputs 0 immediately. Reload, restart and reach PASS.
